seg8_scan_driver: RTL
=====================

Name: seg8_scan_driver

Overview:
- Downstream consumer of the clock/calendar core's packed 32-bit display word.
- Time-multiplexes eight common-anode seven-segment digits, decoding 4-bit codes to glyphs.
- Supports per-digit blink (for the field being edited), per-digit enable and per-digit decimal point.
- Latches data once per frame to prevent tearing, and inserts a blanking gap between digits to suppress ghosting.

Parameters:
SCAN_DIV, 49_999, cycles per digit slot minus 1 (1 ms at 50 MHz)
BLANK_CYC, 500, cycles at the start of each slot with all digits off; must be < SCAN_DIV+1
BLINK_DIV, 12_499_999, cycles per blink half-period minus 1 (2 Hz blink at 50 MHz)

Ports:
Clk  in  1  system clock, 50 MHz
Reset_n  in  1  asynchronous active-low reset
Disp_Data  in  32  digit i code = Disp_Data[4i+3:4i], i=0..7
Blink_Mask  in  8  1 = digit i blinks
Dig_En  in  8  1 = digit i enabled; 0 = dark
Dp_Mask  in  8  1 = decimal point lit on digit i
SEL  out  8  active-low one-hot digit select; SEL[i]=0 drives digit i
SEG  out  8  active-low segments {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset_n is asynchronous, active-low; clock is Clk. All state is on posedge Clk / negedge Reset_n.
- Reset values: SEL=8'hFF, SEG=8'hFF, div_cnt=0, idx=0, blink_on=1, and all frame latches (data/blink/en/dp) cleared to 0. Display stays dark until the first frame latch.
- Slot counter div_cnt counts 0..SCAN_DIV, then wraps to 0. On wrap, idx (3 bits) increments modulo 8 (7 -> 0).
- Frame latch: when div_cnt==SCAN_DIV and idx==7, latch Disp_Data, Blink_Mask, Dig_En and Dp_Mask. Slot 0 of the next frame onward uses the new values.
  - Input changes mid-frame are invisible until the next frame boundary.
- Blink timer: blink_cnt counts 0..BLINK_DIV, wraps, and toggles blink_on on each wrap. It is free-running and independent of the scan.
- Visibility for slot k: vis = en_l[k] & ~(blink_l[k] & ~blink_on).
- Output register (1-cycle latency from div_cnt/idx):
  - If div_cnt < BLANK_CYC, or vis=0: SEL=8'hFF, SEG=8'hFF.
  - Otherwise: SEL=~(8'b1<<idx), SEG[6:0]=glyph(data_l[4k+3:4k]), SEG[7]=~dp_l[k].
- Glyph table (SEG[6:0] as hex incl. dp=1):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E
  - Dp clears bit 7.
- Invariant: at most one SEL bit is low in any cycle.
- Reset asserted mid-frame: outputs go to FF immediately (asynchronous) and the frame restarts at idx=0 after release.

Test Plan:
(bench params: SCAN_DIV=9, BLANK_CYC=2, BLINK_DIV=99)
- Reset release, Disp_Data=32'h76543210, Dig_En=FF, masks 0 -> SEL/SEG stay FF for the first frame (80 cycles). Then in slot k, cycles 3..10 of the slot (1-cycle output latency): SEL=~(1<<k), SEG=glyph(k), e.g. slot 3 SEG=B0. Blank cycles give FF.
- Change Disp_Data to 32'hFFFFFFFF at idx=3 -> digits 4..7 still show 4..7 in the current frame; all digits show 8E from the next frame.
- Dig_En=8'b1111_1110 -> slot 0 SEL=FF, SEG=FF for the whole slot; other slots unaffected.
- Blink_Mask=8'h01 -> digit 0 lit while blink_on=1, dark for the 100-cycle half-periods where blink_on=0; digit 1 never blanks.
- Dp_Mask=8'h24, Disp_Data=32'hAAAAAAAA -> slots 2 and 5 SEG=08, others 88.
- Assert Reset_n low at idx=5, mid-slot -> SEL=SEG=FF in the same cycle, without waiting for a clock edge. After release, scan restarts at idx 0 and the display stays dark until the new frame latch.
- Continuous check over 10 frames: the count of low bits in SEL is never greater than 1.

Source files
------------

// File: rtl/seg8_scan_driver.sv
// Eight-digit common-anode 7-seg scanner: frame-latched data, per-digit blink/enable/dp, blank gap per slot.
// Outputs registered one cycle after div_cnt/idx; no backpressure, inputs are sampled once per frame.
module seg8_scan_driver #(
    parameter int SCAN_DIV  = 49_999,
    parameter int BLANK_CYC = 500,
    parameter int BLINK_DIV = 12_499_999
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] Disp_Data,
    input  logic [7:0]  Blink_Mask,
    input  logic [7:0]  Dig_En,
    input  logic [7:0]  Dp_Mask,
    output logic [7:0]  SEL,
    output logic [7:0]  SEG
);

    localparam int DW = $clog2(SCAN_DIV + 2);
    localparam int BW = $clog2(BLINK_DIV + 2);

    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic [31:0]   data_l;
    logic [7:0]    blink_l;
    logic [7:0]    en_l;
    logic [7:0]    dp_l;

    logic          slot_end;
    logic          vis;
    logic [3:0]    code;
    logic [7:0]    sel_nxt;
    logic [7:0]    seg_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    assign slot_end = (div_cnt == DW'(SCAN_DIV));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Latch at the last cycle of slot 7 so a whole frame shows one consistent snapshot.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_l  <= '0;
            blink_l <= '0;
            en_l    <= '0;
            dp_l    <= '0;
        end else if (slot_end && idx == 3'd7) begin
            data_l  <= Disp_Data;
            blink_l <= Blink_Mask;
            en_l    <= Dig_En;
            dp_l    <= Dp_Mask;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_comb begin
        sel_nxt = 8'hFF;
        seg_nxt = 8'hFF;
        code    = data_l[idx*4 +: 4];
        vis     = en_l[idx] & ~(blink_l[idx] & ~blink_on);
        if (div_cnt >= DW'(BLANK_CYC) && vis) begin
            sel_nxt = ~(8'h01 << idx);
            seg_nxt = {~dp_l[idx], glyph(code)};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            SEL <= 8'hFF;
            SEG <= 8'hFF;
        end else begin
            SEL <= sel_nxt;
            SEG <= seg_nxt;
        end
    end

endmodule
